// File: rtl/spm_dest_regs.sv
// Destination register bank of the RISC SPM datapath: captures bus2 into one
// selected register, keeps the zero flag and auto-increments the PC.
module spm_dest_regs #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] PC_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus2,
  input  logic             ld_en,
  input  logic [2:0]       sel_dest,
  input  logic             inc_pc,
  input  logic             ld_z,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ir,
  output logic [WIDTH-1:0] add_r,
  output logic [WIDTH-1:0] reg_y,
  output logic             z_flag,
  output logic             wr_ack,
  output logic             pc_wrap
);

  localparam logic [2:0] SEL_PC    = 3'd4;
  localparam logic [2:0] SEL_IR    = 3'd5;
  localparam logic [2:0] SEL_ADD_R = 3'd6;
  localparam logic [2:0] SEL_REG_Y = 3'd7;

  logic [7:0]       w_sel_hit;
  logic             w_pc_inc;
  logic [WIDTH-1:0] r_gpr [4];
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_add_r;
  logic [WIDTH-1:0] r_reg_y;
  logic             r_z_flag;
  logic             r_wr_ack;
  logic             r_pc_wrap;

  // Decode is gated by ld_en so an unknown sel_dest while idle selects nothing.
  assign w_sel_hit = ld_en ? (8'b1 << sel_dest) : 8'b0;
  assign w_pc_inc  = inc_pc & ~w_sel_hit[SEL_PC];

  for (genvar gi = 0; gi < 4; gi++) begin : g_gpr
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_gpr[gi] <= '0;
      end else if (w_sel_hit[gi]) begin
        r_gpr[gi] <= bus2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir    <= '0;
      r_add_r <= '0;
      r_reg_y <= '0;
    end else begin
      if (w_sel_hit[SEL_IR])    r_ir    <= bus2;
      if (w_sel_hit[SEL_ADD_R]) r_add_r <= bus2;
      if (w_sel_hit[SEL_REG_Y]) r_reg_y <= bus2;
    end
  end

  // A PC load wins over the increment; only the increment path can flag a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= PC_RST;
      r_pc_wrap <= 1'b0;
    end else begin
      r_pc_wrap <= w_pc_inc & (&r_pc);
      if (w_sel_hit[SEL_PC]) begin
        r_pc <= bus2;
      end else if (w_pc_inc) begin
        r_pc <= r_pc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z_flag <= 1'b0;
      r_wr_ack <= 1'b0;
    end else begin
      r_wr_ack <= ld_en;
      if (ld_z) r_z_flag <= alu_zero;
    end
  end

  assign r0      = r_gpr[0];
  assign r1      = r_gpr[1];
  assign r2      = r_gpr[2];
  assign r3      = r_gpr[3];
  assign pc      = r_pc;
  assign ir      = r_ir;
  assign add_r   = r_add_r;
  assign reg_y   = r_reg_y;
  assign z_flag  = r_z_flag;
  assign wr_ack  = r_wr_ack;
  assign pc_wrap = r_pc_wrap;

endmodule

// File: tb/tb_spm_dest_regs.sv
// Scoreboard bench for spm_dest_regs: stimulus pushes expected bank state,
// a monitor pops and compares it after each capturing edge.
module tb_spm_dest_regs;

  typedef struct packed {
    logic [7:0] r0, r1, r2, r3, pc, ir, add_r, reg_y;
    logic       z, ack, wrap;
  } st_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bus2 = 8'h00;
  logic       ld_en = 1'b0;
  logic [2:0] sel_dest = 3'd0;
  logic       inc_pc = 1'b0;
  logic       ld_z = 1'b0;
  logic       alu_zero = 1'b0;
  logic [7:0] r0, r1, r2, r3, pc, ir, add_r, reg_y;
  logic       z_flag, wr_ack, pc_wrap;

  int total = 0;
  int bad   = 0;
  st_t m;
  st_t exp_q[$];
  string name_q[$];

  spm_dest_regs #(.WIDTH(8), .PC_RST(8'h00)) dut (
    .clk(clk), .rst(rst), .bus2(bus2), .ld_en(ld_en), .sel_dest(sel_dest),
    .inc_pc(inc_pc), .ld_z(ld_z), .alu_zero(alu_zero),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .pc(pc), .ir(ir), .add_r(add_r),
    .reg_y(reg_y), .z_flag(z_flag), .wr_ack(wr_ack), .pc_wrap(pc_wrap)
  );

  always #5 clk = ~clk;

  function automatic st_t dut_state();
    st_t s;
    s = '{r0: r0, r1: r1, r2: r2, r3: r3, pc: pc, ir: ir, add_r: add_r,
          reg_y: reg_y, z: z_flag, ack: wr_ack, wrap: pc_wrap};
    return s;
  endfunction

  task automatic check_state(input string nm, input st_t exp);
    st_t act;
    act = dut_state();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got r=%h %h %h %h pc=%h ir=%h ar=%h ry=%h z=%b ack=%b wrap=%b want r=%h %h %h %h pc=%h ir=%h ar=%h ry=%h z=%b ack=%b wrap=%b",
               nm, act.r0, act.r1, act.r2, act.r3, act.pc, act.ir, act.add_r, act.reg_y,
               act.z, act.ack, act.wrap, exp.r0, exp.r1, exp.r2, exp.r3, exp.pc, exp.ir,
               exp.add_r, exp.reg_y, exp.z, exp.ack, exp.wrap);
    end else begin
      $display("ok   %s: pc=%h ack=%b wrap=%b z=%b", nm, act.pc, act.ack, act.wrap, act.z);
    end
  endtask

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Drive one cycle of stimulus at a falling edge and queue the state expected
  // after the following rising edge.
  task automatic step(input string nm, input logic ld, input logic [2:0] sel,
                      input logic [7:0] d, input logic inc, input logic lz,
                      input logic az);
    st_t nx;
    ld_en = ld; sel_dest = sel; bus2 = d; inc_pc = inc; ld_z = lz; alu_zero = az;
    nx = m;
    nx.ack  = ld;
    nx.wrap = 1'b0;
    if (ld) begin
      case (sel)
        3'd0: nx.r0    = d;
        3'd1: nx.r1    = d;
        3'd2: nx.r2    = d;
        3'd3: nx.r3    = d;
        3'd4: nx.pc    = d;
        3'd5: nx.ir    = d;
        3'd6: nx.add_r = d;
        default: nx.reg_y = d;
      endcase
    end
    if (inc && !(ld && sel == 3'd4)) begin
      nx.pc   = m.pc + 8'h01;
      nx.wrap = (m.pc == 8'hFF);
    end
    if (lz) nx.z = az;
    m = nx;
    exp_q.push_back(m);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic idle(input string nm);
    step(nm, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare after every rising edge for which an expectation is queued.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      check_state(name_q.pop_front(), exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
    #1;
    check_state("reset_initial", '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Make state non-zero, then reset mid-cycle with a load and inc pending.
    step("pre_r0", 1'b1, 3'd0, 8'h5A, 1'b1, 1'b1, 1'b1);
    ld_en = 1'b1; sel_dest = 3'd0; bus2 = 8'hAA; inc_pc = 1'b1;
    #3 rst = 1'b1;
    m = '0;
    #1 check_state("reset_async", m);
    @(posedge clk); #2 check_state("reset_held", m);
    @(negedge clk);
    ld_en = 1'b0; inc_pc = 1'b0;
    rst = 1'b0;

    // Destination decode, including wr_ack back-to-back.
    for (int c = 0; c < 8; c++) begin
      step($sformatf("decode_%0d", c), 1'b1, 3'(c), 8'h10 + 8'(c), 1'b0, 1'b0, 1'b0);
    end
    idle("decode_ack_drop");
    check8("decode_r2", r2, 8'h12);
    check8("decode_reg_y", reg_y, 8'h17);

    // Unknown select while not loading disturbs nothing.
    step("x_sel_idle", 1'b0, 3'bxxx, 8'hEE, 1'b0, 1'b0, 1'b0);

    // PC load has priority over increment.
    step("pc_load_05", 1'b1, 3'd4, 8'h05, 1'b0, 1'b0, 1'b0);
    step("pc_prio", 1'b1, 3'd4, 8'h40, 1'b1, 1'b0, 1'b0);
    check8("pc_prio_hand", pc, 8'h40);
    step("pc_inc", 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    check8("pc_inc_hand", pc, 8'h41);

    // Wrap via increment pulses once; wrap to zero via load does not.
    step("wrap_load_ff", 1'b1, 3'd4, 8'hFF, 1'b0, 1'b0, 1'b0);
    step("wrap_inc", 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    check8("wrap_flag_hand", {7'b0, pc_wrap}, 8'h01);
    idle("wrap_clear");
    step("load_ff_again", 1'b1, 3'd4, 8'hFF, 1'b0, 1'b0, 1'b0);
    step("load_00_nowrap", 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0);
    check8("load_00_wrap_hand", {7'b0, pc_wrap}, 8'h00);

    // Concurrent R2 load, PC increment and zero-flag load.
    step("concurrent", 1'b1, 3'd2, 8'h3C, 1'b1, 1'b1, 1'b1);
    check8("concurrent_r2_hand", r2, 8'h3C);
    check8("concurrent_pc_hand", pc, 8'h01);
    step("z_hold", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    check8("z_hold_hand", {7'b0, z_flag}, 8'h01);
    step("z_clear", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset mid-load targeting R3: load is discarded.
    ld_en = 1'b1; sel_dest = 3'd3; bus2 = 8'h77;
    #3 rst = 1'b1;
    m = '0;
    #1 check_state("rst_midload", m);
    @(negedge clk);
    ld_en = 1'b0;
    rst = 1'b0;
    idle("after_rst_release");
    check8("rst_midload_r3_hand", r3, 8'h00);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spm_dest_regs.md
# spm_dest_regs

Write-side register bank of the RISC SPM datapath: it captures the 8-bit bus2 value into one selected destination (R0–R3, PC, IR, ADD_R, REG_Y) under controller command, maintains the zero flag, and auto-increments the PC. Its registered outputs drive the bus1 source selection and the memory address path. It is the sink end of the datapath buses, whereas the bus1 source selection is the read end.

## Interface

Parameters:
- `WIDTH`, 8, datapath word width for all registers and bus2.
- `PC_RST`, 8'h00, PC value after reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `bus2` in WIDTH: write data.
- `ld_en` in 1: load strobe for the destination named by `sel_dest`.
- `sel_dest` in 3: destination code; 0 R0, 1 R1, 2 R2, 3 R3, 4 PC, 5 IR, 6 ADD_R, 7 REG_Y.
- `inc_pc` in 1: PC += 1 request.
- `ld_z` in 1: load zero flag.
- `alu_zero` in 1: zero result from the ALU.
- `r0`, `r1`, `r2`, `r3`, `pc`, `ir`, `add_r`, `reg_y` out WIDTH: registered contents.
- `z_flag` out 1: registered zero flag.
- `wr_ack` out 1: one-cycle pulse, high the cycle after any accepted `ld_en`.
- `pc_wrap` out 1: one-cycle pulse, high the cycle after PC increments from all-ones to zero.

## Operation

- Reset (async, `rst`=1): R0–R3, IR, ADD_R and REG_Y clear to 0. PC is set to `PC_RST`. `z_flag`, `wr_ack` and `pc_wrap` clear to 0. Outputs hold these values for as long as `rst` is high, regardless of other inputs.
- Load: when `ld_en`=1 at a rising edge, the register selected by `sel_dest` takes `bus2`. All other registers hold. `sel_dest` is fully decoded, so every code is valid and there is no default case.
- PC update priority at each edge:
  - `ld_en`=1 with `sel_dest`=4: PC takes `bus2`, and `inc_pc` is ignored that cycle.
  - Otherwise, if `inc_pc`=1: PC takes PC+1, modulo 2^WIDTH.
  - Otherwise PC holds.
- Simultaneous `ld_en` to a non-PC destination and `inc_pc`: both take effect in the same edge.
- `pc_wrap`: set for one cycle when the increment path is taken with PC = all-ones, so PC becomes 0. It is not set when PC reaches 0 by a load.
- Zero flag: when `ld_z`=1, `z_flag` takes `alu_zero`; otherwise it holds. `ld_z` is independent of `ld_en`.
- `wr_ack`: registered copy of `ld_en`. Back-to-back loads give a continuous high `wr_ack`.
- No read-during-write bypass. An output shows the new value only after the capturing edge; `bus2` never passes combinationally to any output.
- Unknown or X on `sel_dest` while `ld_en`=0 must not disturb any register.

## Timing

- Latency from a load or increment to the output is 1 edge. Data present with `ld_en` at edge N appears on the register output after edge N.
- `wr_ack` and `pc_wrap` are high for exactly the cycle following the triggering edge.
- Reset assertion takes effect immediately, with no clock needed. Reset deassertion is synchronised externally. The first update occurs at the first rising edge with `rst`=0.
- Reset mid-operation, e.g. `rst` rising while `ld_en`=1: every register takes its reset value at once, and the pending load is discarded.
- The bank has no combinational input-to-output paths. Outputs are all flop-driven, safe to feed the bus1 source select.

## Test plan

- Reset: pulse `rst` with `bus2`=8'hAA, `ld_en`=1 and `inc_pc`=1 mid-cycle -> all registers 0, PC=8'h00, `z_flag`/`wr_ack`/`pc_wrap`=0 immediately and while `rst` is held.
- Destination decode: for `sel_dest`=0..7, load `bus2`=8'h10+code -> only the addressed register changes, with the new value visible after one edge, and `wr_ack` pulses once per load.
- PC priority: PC=8'h05, `ld_en`=1, `sel_dest`=4, `bus2`=8'h40, `inc_pc`=1 -> PC=8'h40, not 8'h06. Next cycle `inc_pc` only -> 8'h41.
- Wrap: load PC=8'hFF, then `inc_pc` -> PC=8'h00 and `pc_wrap`=1 for exactly one cycle. Loading PC=8'h00 directly -> `pc_wrap` stays 0.
- Concurrent ops: `ld_en` to R2 with 8'h3C, `inc_pc`=1, `ld_z`=1 and `alu_zero`=1 in the same cycle -> R2=8'h3C, PC+1, `z_flag`=1. Next cycle `ld_z`=0 with `alu_zero`=0 -> `z_flag` stays 1.
- Reset mid-load: assert `rst` between edges while `ld_en`=1 targets R3 with 8'h77 -> R3 stays 0 and `wr_ack` stays 0 after release.
